// File: rtl/fused_ofm_writeback_pkg.sv
// Shared constants, FSM state type and sizing helper for the OFM writeback stage.
package fused_pkg;

  localparam int DATA_W = 8;
  localparam int BEAT_W = 128;
  localparam int LANES  = BEAT_W / DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // Ceiling divide without forming n + d - 1, so large n cannot overflow.
  function automatic logic [31:0] ceil_div(input logic [31:0] n, input logic [31:0] d);
    return (n / d) + (((n % d) != 32'd0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/fused_ofm_writeback_if.sv
// Element stream from the fused block plus the global BRAM write port.
//
// Handshake: an element transfers on every rising clk edge where
// valid_layer2 && ready_layer2. ready_layer2 never depends on valid_layer2,
// and when ready_layer2 is low valid_layer2/data_layer2 are ignored.
// The BRAM port has no back-channel beyond grant_global: a beat is written on
// every cycle where we_global is high, with wr_addr_global/wr_data_global valid.
interface fused_ofm_writeback_if
  import fused_pkg::*;
#(
  parameter int DATA_W = fused_pkg::DATA_W,
  parameter int BEAT_W = fused_pkg::BEAT_W
);
  logic              valid_layer2;
  logic [DATA_W-1:0] data_layer2;
  logic              ready_layer2;
  logic              grant_global;
  logic [31:0]       wr_addr_global;
  logic [BEAT_W-1:0] wr_data_global;
  logic              we_global;

  // Environment side: produces elements and grants, observes writes.
  modport master (
    output valid_layer2, data_layer2, grant_global,
    input  ready_layer2, wr_addr_global, wr_data_global, we_global
  );

  // Writeback block side.
  modport slave (
    input  valid_layer2, data_layer2, grant_global,
    output ready_layer2, wr_addr_global, wr_data_global, we_global
  );
endinterface

// File: rtl/fused_ofm_writeback_fifo.sv
// Small synchronous beat FIFO with show-ahead read data and simultaneous push/pop.
module fused_beat_fifo
  import fused_pkg::*;
#(
  parameter int W     = BEAT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  // Pointer update; push and pop in one cycle both advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fused_ofm_writeback.sv
// Packs layer-2 elements into BRAM-wide beats, buffers them and writes them
// to global BRAM at consecutive addresses, then pulses done.
module fused_ofm_writeback
  import fused_pkg::*;
#(
  parameter int DATA_W     = fused_pkg::DATA_W,
  parameter int BEAT_W     = fused_pkg::BEAT_W,
  parameter int ADDR_STEP  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [31:0]             base_addr_OFM,
  input  logic [31:0]             size_OFM,
  fused_ofm_writeback_if.slave    bus,
  output logic                    busy,
  output logic                    done,
  output wb_state_t               dbg_state
);

  localparam int NLANES     = BEAT_W / DATA_W;
  localparam int LANE_W     = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int ELEM_SHIFT = $clog2(DATA_W / 8);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANES - 1);

  wb_state_t         state, state_nxt;
  logic [LANE_W-1:0] lane_cnt;
  logic [31:0]       elem_cnt;
  logic [31:0]       beat_cnt;
  logic [31:0]       n_elem;
  logic [31:0]       n_beat;
  logic [31:0]       wr_addr_next;
  logic [BEAT_W-1:0] pack_buf;

  logic [31:0]       start_n_elem;
  logic              accept;
  logic              flush_push;
  logic [BEAT_W-1:0] beat_filled;
  logic              push;
  logic [BEAT_W-1:0] push_data;
  logic              pop;
  logic [BEAT_W-1:0] pop_data;
  logic              fifo_full;
  logic              fifo_empty;

  assign start_n_elem     = size_OFM >> ELEM_SHIFT;
  assign bus.ready_layer2 = (state == RUN) && (elem_cnt < n_elem) && !fifo_full;
  assign accept           = bus.valid_layer2 && bus.ready_layer2;
  assign flush_push       = (state == FLUSH) && (lane_cnt != '0) && !fifo_full;
  assign pop              = !fifo_empty && bus.grant_global;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign dbg_state        = state;

  // Current beat with the incoming element dropped into its lane.
  always_comb begin
    beat_filled = pack_buf;
    beat_filled[lane_cnt*DATA_W +: DATA_W] = bus.data_layer2;
  end

  // FIFO push: a completed beat on the last lane, or the zero-padded tail in FLUSH.
  always_comb begin
    push      = 1'b0;
    push_data = pack_buf;
    if (accept && (lane_cnt == LAST_LANE)) begin
      push      = 1'b1;
      push_data = beat_filled;
    end else if (flush_push) begin
      push      = 1'b1;
      push_data = pack_buf;
    end
  end

  fused_beat_fifo #(
    .W     (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (start_n_elem == 32'd0) ? FLUSH : RUN;
      RUN:   if (accept && (elem_cnt == n_elem - 32'd1)) state_nxt = FLUSH;
      FLUSH: if ((beat_cnt == n_beat) && (lane_cnt == '0)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer parameters, packer and counters; start only lands in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt     <= '0;
      elem_cnt     <= '0;
      beat_cnt     <= '0;
      n_elem       <= '0;
      n_beat       <= '0;
      wr_addr_next <= '0;
      pack_buf     <= '0;
    end else if ((state == IDLE) && start) begin
      lane_cnt     <= '0;
      elem_cnt     <= '0;
      beat_cnt     <= '0;
      n_elem       <= start_n_elem;
      n_beat       <= ceil_div(start_n_elem, 32'(NLANES));
      wr_addr_next <= base_addr_OFM;
      pack_buf     <= '0;
    end else begin
      if (accept) begin
        elem_cnt <= elem_cnt + 32'd1;
        if (lane_cnt == LAST_LANE) begin
          lane_cnt <= '0;
          pack_buf <= '0;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
          pack_buf <= beat_filled;
        end
      end else if (flush_push) begin
        lane_cnt <= '0;
        pack_buf <= '0;
      end
      if (pop) begin
        beat_cnt     <= beat_cnt + 32'd1;
        wr_addr_next <= wr_addr_next + 32'(ADDR_STEP);
      end
    end
  end

  // BRAM write port: one strobe the cycle after each pop; address/data hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.we_global      <= 1'b0;
      bus.wr_addr_global <= '0;
      bus.wr_data_global <= '0;
    end else begin
      bus.we_global <= pop;
      if (pop) begin
        bus.wr_addr_global <= wr_addr_next;
        bus.wr_data_global <= pop_data;
      end
    end
  end

endmodule

// File: tb/tb_fused_ofm_writeback.sv
// Directed bench for fused_ofm_writeback with an expected-write scoreboard.
module tb_fused_ofm_writeback;
  import fused_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr_OFM = '0;
  logic [31:0] size_OFM = '0;
  logic        busy;
  logic        done;
  wb_state_t   dbg_state;

  fused_ofm_writeback_if bus ();

  fused_ofm_writeback dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr_OFM (base_addr_OFM),
    .size_OFM      (size_OFM),
    .bus           (bus.slave),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: each entry is {addr, data}.
  logic [159:0] exp_q[$];
  logic [7:0]   elems [256];
  int           sent;
  int           checks = 0;
  int           passes = 0;
  int           fails = 0;
  int           write_count = 0;
  int           last_we_cyc = -10;
  int           done_cyc = 0;
  int           start_cyc = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats for n elements from elems[], lanes past the end are zero.
  task automatic build_expected(input logic [31:0] base, input int n);
    int nb;
    logic [127:0] d;
    nb = (n + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < 16; k++)
        if (b * 16 + k < n) d[k*8 +: 8] = elems[b*16 + k];
      exp_q.push_back({base + 32'(b * 16), d});
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] size);
    @(negedge clk);
    start = 1'b1;
    base_addr_OFM = base;
    size_OFM = size;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    sent = 0;
  endtask

  // Offer elems[sent..n-1] one per cycle, bounded by max_cycles.
  task automatic drive_elems(input int n, input int max_cycles);
    logic r;
    for (int c = 0; c < max_cycles && sent < n; c++) begin
      @(negedge clk);
      bus.valid_layer2 = 1'b1;
      bus.data_layer2 = elems[sent];
      #1;
      r = bus.ready_layer2;
      @(posedge clk);
      if (r) sent++;
    end
    @(negedge clk);
    bus.valid_layer2 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    check({tag, "_done_seen"}, 160'(seen), 160'(1));
    if (seen) begin
      check({tag, "_busy_in_done"}, 160'(busy), 160'(1));
      @(negedge clk);
      check({tag, "_done_pulse_width"}, 160'(done), 160'(0));
      check({tag, "_idle_after_done"}, 160'(busy), 160'(0));
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && bus.we_global) begin
      write_count++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_write", 160'(1), 160'(0));
      else check("write_beat", {bus.wr_addr_global, bus.wr_data_global}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    bus.valid_layer2 = 1'b0;
    bus.data_layer2 = '0;
    bus.grant_global = 1'b1;
    sent = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_we", 160'(bus.we_global), 160'(0));
    check("rst_addr", 160'(bus.wr_addr_global), 160'(0));
    check("rst_data", 160'(bus.wr_data_global), 160'(0));
    check("rst_busy_done", {busy, done, bus.ready_layer2}, 160'(0));
    check("rst_state", 160'(dbg_state), 160'(IDLE));
    reset_n = 1'b1;

    // Exact multiple: 64 elements 0..63 -> 4 beats from 0x1000.
    for (int i = 0; i < 64; i++) elems[i] = 8'(i);
    build_expected(32'h1000, 64);
    start_xfer(32'h1000, 32'd64);
    check("t1_state_run", 160'(dbg_state), 160'(RUN));
    drive_elems(64, 200);
    check("t1_sent", 160'(sent), 160'(64));
    wait_done("t1", 50);
    check("t1_done_after_last_write", 160'(done_cyc), 160'(last_we_cyc + 1));
    check("t1_q_empty", 160'(exp_q.size()), 160'(0));

    // Partial beat: 20 elements -> second beat zero-padded; extras not consumed.
    for (int i = 0; i < 20; i++) elems[i] = 8'($urandom_range(0, 255));
    build_expected(32'h5000, 20);
    start_xfer(32'h5000, 32'd20);
    drive_elems(20, 100);
    check("t2_sent", 160'(sent), 160'(20));
    bus.valid_layer2 = 1'b1;
    #1;
    check("t2_no_ready_after_last", 160'(bus.ready_layer2), 160'(0));
    bus.valid_layer2 = 1'b0;
    wait_done("t2", 50);
    check("t2_done_after_last_write", 160'(done_cyc), 160'(last_we_cyc + 1));
    check("t2_q_empty", 160'(exp_q.size()), 160'(0));

    // Backpressure: grant withheld, FIFO fills at 4 beats.
    bus.grant_global = 1'b0;
    for (int i = 0; i < 128; i++) elems[i] = 8'($urandom_range(0, 255));
    build_expected(32'h6000, 128);
    start_xfer(32'h6000, 32'd128);
    drive_elems(128, 80);
    check("t3_sent_while_blocked", 160'(sent), 160'(64));
    check("t3_ready_low_full", 160'(bus.ready_layer2), 160'(0));
    check("t3_no_writes_yet", 160'(exp_q.size()), 160'(8));
    bus.grant_global = 1'b1;
    drive_elems(128, 400);
    check("t3_sent_all", 160'(sent), 160'(128));
    wait_done("t3", 100);
    check("t3_q_empty", 160'(exp_q.size()), 160'(0));

    // Zero size: no writes, done within 3 cycles of start.
    wc0 = write_count;
    start_xfer(32'h7000, 32'd0);
    wait_done("t4", 5);
    check("t4_done_latency_ok", 160'((done_cyc - start_cyc) <= 3), 160'(1));
    check("t4_no_writes", 160'(write_count), 160'(wc0));

    // Start while busy is dropped.
    for (int i = 0; i < 64; i++) elems[i] = 8'($urandom_range(0, 255));
    build_expected(32'h2000, 64);
    start_xfer(32'h2000, 32'd64);
    drive_elems(10, 50);
    start_xfer(32'h9000, 32'd32);
    sent = 10;
    drive_elems(64, 300);
    check("t5_sent", 160'(sent), 160'(64));
    wait_done("t5", 50);
    check("t5_q_empty", 160'(exp_q.size()), 160'(0));

    // Reset mid-RUN, then a clean transfer from a new base.
    for (int i = 0; i < 64; i++) elems[i] = 8'($urandom_range(0, 255));
    build_expected(32'h3000, 64);
    start_xfer(32'h3000, 32'd64);
    drive_elems(20, 100);
    check("t6_one_beat_written", 160'(exp_q.size()), 160'(3));
    reset_n = 1'b0;
    #1;
    check("t6_rst_we", 160'(bus.we_global), 160'(0));
    check("t6_rst_addr_data", {bus.wr_addr_global, bus.wr_data_global}, 160'(0));
    check("t6_rst_flags", {busy, done, bus.ready_layer2}, 160'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 48; i++) elems[i] = 8'($urandom_range(0, 255));
    build_expected(32'hFFFF_FFE0, 48);
    start_xfer(32'hFFFF_FFE0, 32'd48);
    drive_elems(48, 200);
    check("t6_sent", 160'(sent), 160'(48));
    wait_done("t6", 50);
    check("t6_q_empty", 160'(exp_q.size()), 160'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
